nanov_spi_mem_arbiter: RTL and testbench

// Sequences the single bit-serial SPI memory bus of the nanoV CPU and shares it between
// two requesters: instruction fetch (read-only, 32-bit) and data load/store (1/2/4 bytes).

---
 rtl/nanov_spi_mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_nanov_spi_mem_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nanov_spi_mem_arbiter.sv
// Shares the nanoV bit-serial SPI memory bus between instruction fetch and data load/store.
// Latency: select drops 1 cycle after grant; done pulses 32+8*nbytes cycles later (fetch: 64).
// Backpressure: requests are held until their done pulse; data wins ties, grants only in IDLE/GAP exit.
module nanov_spi_mem_arbiter #(
  parameter int          ADDR_BITS = 24,
  parameter int          CS_GAP    = 1,
  parameter logic [7:0]  CMD_READ  = 8'h03,
  parameter logic [7:0]  CMD_WRITE = 8'h02
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 f_req,
  input  logic [ADDR_BITS-1:0] f_addr,
  output logic                 f_done,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [1:0]           d_len,
  input  logic [ADDR_BITS-1:0] d_addr,
  input  logic [31:0]          d_wdata,
  output logic                 d_done,
  output logic [31:0]          rdata,
  output logic                 busy,
  output logic                 spi_select,
  output logic                 spi_out,
  input  logic                 spi_data_in
);

  // Outgoing stream is {cmd, addr, up to four data bytes}, MSB of the vector goes out first.
  localparam int TXW = 8 + ADDR_BITS + 32;
  localparam int IW  = $clog2(TXW + 1);
  localparam int GW  = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [IW-1:0] CMD_END  = IW'(8);
  localparam logic [IW-1:0] ADDR_END = IW'(8 + ADDR_BITS);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DONE, GAP} state_t;

  state_t          state;
  logic [TXW-1:0]  tx;
  logic [31:0]     rx;
  logic [IW-1:0]   bit_idx;
  logic [IW-1:0]   last_idx;
  logic [2:0]      nbytes;
  logic            is_read;
  logic            is_fetch;
  logic [GW-1:0]   gap_cnt;

  logic            can_grant;
  logic            grant_d;
  logic            grant_f;
  logic            g_write;
  logic [2:0]      g_nbytes;
  logic [ADDR_BITS-1:0] g_addr;
  logic [TXW-1:0]  tx_init;
  logic [IW-1:0]   g_last;
  logic [IW-1:0]   next_idx;
  logic [31:0]     rx_next;
  logic [31:0]     rd_fmt;

  // Arbitration, transaction setup values and read-data byte reordering.
  always_comb begin
    can_grant = (state == IDLE) || ((state == GAP) && (gap_cnt == '0));
    grant_d   = can_grant && d_req;
    grant_f   = can_grant && !d_req && f_req;
    g_write   = grant_d && d_we;
    g_nbytes  = 3'd4;
    if (grant_d) begin
      case (d_len)
        2'd0:    g_nbytes = 3'd1;
        2'd1:    g_nbytes = 3'd2;
        default: g_nbytes = 3'd4;
      endcase
    end
    g_addr   = grant_d ? d_addr : f_addr;
    // Write bytes go out in byte-0-first order, so byte 0 lands at the top.
    tx_init  = {(g_write ? CMD_WRITE : CMD_READ), g_addr,
                (g_write ? {d_wdata[7:0], d_wdata[15:8], d_wdata[23:16], d_wdata[31:24]} : 32'h0)};
    g_last   = ADDR_END + IW'({g_nbytes, 3'b000}) - IW'(1);
    next_idx = bit_idx + IW'(1);
    // Includes the bit sampled on the current edge so the last bit reaches rdata.
    rx_next  = {rx[30:0], spi_data_in};
    case (nbytes)
      3'd1:    rd_fmt = {24'h0, rx_next[7:0]};
      3'd2:    rd_fmt = {16'h0, rx_next[7:0], rx_next[15:8]};
      default: rd_fmt = {rx_next[7:0], rx_next[15:8], rx_next[23:16], rx_next[31:24]};
    endcase
  end

  // Bus sequencer: one stream bit per select-low cycle, then DONE pulse and chip-select gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tx         <= '0;
      rx         <= '0;
      bit_idx    <= '0;
      last_idx   <= '0;
      nbytes     <= 3'd4;
      is_read    <= 1'b0;
      is_fetch   <= 1'b0;
      gap_cnt    <= '0;
      f_done     <= 1'b0;
      d_done     <= 1'b0;
      rdata      <= '0;
      busy       <= 1'b0;
      spi_select <= 1'b1;
      spi_out    <= 1'b0;
    end else begin
      f_done <= 1'b0;
      d_done <= 1'b0;
      case (state)
        IDLE: ;
        CMD, ADDR, DATA: begin
          if (state == DATA && is_read) rx <= rx_next;
          if (bit_idx == last_idx) begin
            state      <= DONE;
            spi_select <= 1'b1;
            spi_out    <= 1'b0;
            if (is_read) rdata <= rd_fmt;
            if (is_fetch) f_done <= 1'b1;
            else          d_done <= 1'b1;
          end else begin
            bit_idx <= next_idx;
            spi_out <= tx[TXW-1];
            tx      <= tx << 1;
            if (next_idx < CMD_END)       state <= CMD;
            else if (next_idx < ADDR_END) state <= ADDR;
            else                          state <= DATA;
          end
        end
        DONE: begin
          busy    <= 1'b0;
          state   <= GAP;
          gap_cnt <= GW'(CS_GAP - 1);
        end
        GAP: begin
          if (gap_cnt == '0) state <= IDLE;
          else               gap_cnt <= gap_cnt - GW'(1);
        end
        default: state <= IDLE;
      endcase
      // A grant overrides the GAP->IDLE step so a held request restarts without an idle cycle.
      if (grant_d || grant_f) begin
        state      <= CMD;
        spi_select <= 1'b0;
        spi_out    <= tx_init[TXW-1];
        tx         <= tx_init << 1;
        rx         <= '0;
        bit_idx    <= '0;
        last_idx   <= g_last;
        nbytes     <= g_nbytes;
        is_read    <= !g_write;
        is_fetch   <= grant_f;
        busy       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nanov_spi_mem_arbiter.sv
// Self-checking bench for nanov_spi_mem_arbiter with a serial memory responder.
// Directed scenarios followed by randomized transactions against a transaction-level model.
// Requests are held until done; a monitor captures the outgoing stream per select-low window.
module tb_nanov_spi_mem_arbiter;

  localparam int CS_GAP = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        f_req = 1'b0;
  logic [23:0] f_addr = '0;
  logic        f_done;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [1:0]  d_len = '0;
  logic [23:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_done;
  logic [31:0] rdata;
  logic        busy;
  logic        spi_select;
  logic        spi_out;
  logic        spi_data_in = 1'b0;

  int          checks = 0;
  int          failures = 0;
  int          low_cnt = 0;
  int          hi_cnt = 0;
  int          gap_before = 0;
  logic [63:0] cap = '0;
  logic        prev_sel = 1'b1;
  logic [31:0] resp_cur = '0;
  logic [31:0] exp_rdata = '0;

  nanov_spi_mem_arbiter #(.ADDR_BITS(24), .CS_GAP(CS_GAP), .CMD_READ(8'h03), .CMD_WRITE(8'h02)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_done(f_done),
    .d_req(d_req), .d_we(d_we), .d_len(d_len), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .rdata(rdata), .busy(busy),
    .spi_select(spi_select), .spi_out(spi_out), .spi_data_in(spi_data_in)
  );

  always #5 clk = ~clk;

  // Memory side: record the stream while select is low and return response bytes MSB first.
  always @(negedge clk) begin
    if (spi_select === 1'b0) begin
      if (prev_sel) begin
        gap_before = hi_cnt;
        low_cnt    = 0;
        cap        = '0;
      end
      cap = {cap[62:0], spi_out};
      if (low_cnt >= 32 && low_cnt < 64)
        spi_data_in = resp_cur[8*((low_cnt-32)/8) + 7 - ((low_cnt-32)%8)];
      else
        spi_data_in = 1'b0;
      low_cnt++;
      hi_cnt   = 0;
      prev_sel = 1'b0;
    end else begin
      hi_cnt++;
      spi_data_in = 1'b0;
      prev_sel    = 1'b1;
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int nbytes_of(input bit isd, input logic [1:0] len);
    if (!isd) return 4;
    return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [63:0] stream_of(input bit wr, input logic [23:0] addr,
                                            input logic [31:0] wdata, input int n);
    logic [63:0] s;
    s = {32'h0, (wr ? 8'h02 : 8'h03), addr};
    for (int j = 0; j < n; j++) s = (s << 8) | {56'h0, (wr ? wdata[8*j +: 8] : 8'h00)};
    return s;
  endfunction

  function automatic logic [31:0] mask_of(input int n);
    return (n == 1) ? 32'h0000_00FF : (n == 2) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  endfunction

  // Waits for a done pulse; optionally disturbs request inputs once the stream is under way.
  task automatic wait_done(input bit scramble, input bit drop, output bit got);
    bit started;
    started = 1'b0;
    got     = 1'b0;
    for (int c = 0; c < 400 && !got; c++) begin
      cyc();
      if (spi_select === 1'b0) started = 1'b1;
      if (f_done === 1'b1 || d_done === 1'b1) got = 1'b1;
      else if (started && low_cnt >= 3) begin
        if (scramble) begin
          f_addr  = 24'($urandom);
          d_addr  = 24'($urandom);
          d_wdata = $urandom;
          d_len   = 2'($urandom);
          d_we    = 1'($urandom);
        end
        if (drop && low_cnt >= 10) begin
          f_req = 1'b0;
          d_req = 1'b0;
        end
      end
    end
  endtask

  // One complete transaction from a single requester, checked against the model.
  task automatic txn(input string tag, input bit isd, input bit we, input logic [1:0] len,
                     input logic [23:0] addr, input logic [31:0] wdata,
                     input logic [31:0] resp, input bit drop);
    int n;
    bit got;
    bit wr;
    n  = nbytes_of(isd, len);
    wr = isd && we;
    resp_cur = resp;
    if (isd) begin
      d_req = 1'b1; d_we = we; d_len = len; d_addr = addr; d_wdata = wdata;
    end else begin
      f_req = 1'b1; f_addr = addr;
    end
    wait_done(1'b1, drop, got);
    if (!wr) exp_rdata = resp & mask_of(n);
    chk({tag, " done_seen"}, 64'(got), 64'd1);
    chk({tag, " done_kind"}, 64'({f_done, d_done}), isd ? 64'd1 : 64'd2);
    chk({tag, " low_cycles"}, 64'(low_cnt), 64'(32 + 8*n));
    chk({tag, " stream"}, cap, stream_of(wr, addr, wdata, n));
    chk({tag, " busy_at_done"}, 64'(busy), 64'd1);
    chk({tag, " select_at_done"}, 64'(spi_select), 64'd1);
    chk({tag, " rdata"}, 64'(rdata), 64'(exp_rdata));
    f_req = 1'b0;
    d_req = 1'b0;
    cyc();
    chk({tag, " single_pulse"}, 64'({f_done, d_done, busy}), 64'd0);
  endtask

  initial begin
    bit got;
    bit seen;

    // Reset state
    repeat (3) cyc();
    chk("rst select", 64'(spi_select), 64'd1);
    chk("rst spi_out", 64'(spi_out), 64'd0);
    chk("rst dones", 64'({f_done, d_done}), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst rdata", 64'(rdata), 64'd0);
    rst = 1'b0;
    cyc();

    // Fetch of 13,05,10,00 and a one-byte write that must not touch rdata
    txn("t1 fetch", 1'b0, 1'b0, 2'd0, 24'h000104, 32'h0, 32'h0010_0513, 1'b0);
    chk("t1 rdata_value", 64'(rdata), 64'h0010_0513);
    txn("t2 write1", 1'b1, 1'b1, 2'd0, 24'h001000, 32'h0000_00A5, 32'hFFFF_FFFF, 1'b0);

    // Simultaneous requests: data first, then fetch after the chip-select gap
    cyc();
    resp_cur = 32'hDEAD_BEEF;
    f_req = 1'b1; f_addr = 24'h000200;
    d_req = 1'b1; d_we = 1'b1; d_len = 2'd1; d_addr = 24'h000300; d_wdata = 32'h0000_BEEF;
    wait_done(1'b0, 1'b0, got);
    chk("t3 first_seen", 64'(got), 64'd1);
    chk("t3 first_is_data", 64'({f_done, d_done}), 64'd1);
    chk("t3 first_stream", cap, stream_of(1'b1, 24'h000300, 32'h0000_BEEF, 2));
    d_req = 1'b0;
    wait_done(1'b0, 1'b0, got);
    exp_rdata = 32'hDEAD_BEEF;
    chk("t3 second_seen", 64'(got), 64'd1);
    chk("t3 second_is_fetch", 64'({f_done, d_done}), 64'd2);
    chk("t3 gap", 64'(gap_before), 64'(CS_GAP + 1));
    chk("t3 fetch_stream", cap, stream_of(1'b0, 24'h000200, 32'h0, 4));
    chk("t3 rdata", 64'(rdata), 64'(exp_rdata));
    f_req = 1'b0;
    cyc();

    // Two-byte read of 34,12
    txn("t4 read2", 1'b1, 1'b0, 2'd1, 24'h000010, 32'h0, 32'h5566_1234, 1'b0);
    chk("t4 rdata_value", 64'(rdata), 64'h0000_1234);

    // Reset in the middle of a fetch
    resp_cur = 32'h1111_2222;
    f_req = 1'b1; f_addr = 24'h000400;
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      cyc();
      if (spi_select === 1'b0 && low_cnt >= 20) seen = 1'b1;
    end
    chk("t5 reached_cycle20", 64'(seen), 64'd1);
    rst = 1'b1;
    cyc();
    exp_rdata = 32'h0;
    chk("t5 select_after_rst", 64'(spi_select), 64'd1);
    chk("t5 busy_after_rst", 64'(busy), 64'd0);
    chk("t5 rdata_after_rst", 64'(rdata), 64'd0);
    f_req = 1'b0;
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (f_done === 1'b1 || d_done === 1'b1) seen = 1'b1;
      cyc();
    end
    chk("t5 no_done", 64'(seen), 64'd0);
    txn("t5 refetch", 1'b0, 1'b0, 2'd0, 24'h000400, 32'h0, 32'h1111_2222, 1'b0);

    // Held fetch request across two transactions
    resp_cur = 32'hCAFE_0001;
    f_req = 1'b1; f_addr = 24'h000800;
    wait_done(1'b0, 1'b0, got);
    chk("t6 first_seen", 64'(got), 64'd1);
    chk("t6 first_rdata", 64'(rdata), 64'hCAFE_0001);
    resp_cur = 32'h0BAD_F00D;
    wait_done(1'b0, 1'b0, got);
    f_req = 1'b0;
    exp_rdata = 32'h0BAD_F00D;
    chk("t6 second_seen", 64'(got), 64'd1);
    chk("t6 gap", 64'(gap_before), 64'(CS_GAP + 1));
    chk("t6 second_stream", cap, stream_of(1'b0, 24'h000800, 32'h0, 4));
    chk("t6 second_rdata", 64'(rdata), 64'(exp_rdata));
    cyc();

    // Randomized transactions, some with the request dropped mid-stream
    for (int i = 0; i < 8; i++) begin
      txn($sformatf("rnd%0d", i), 1'($urandom), 1'($urandom), 2'($urandom),
          24'($urandom), $urandom, $urandom, (i % 3) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
